// File: rtl/mem_line_arbiter.sv
// Arbiter that shares one line-granular memory port between ICache refill
// reads, DCache refill reads and DCache write-backs. One transaction is in
// flight at a time. Addresses are line-aligned at grant, and each response
// goes back to the requester that won the grant.
module mem_line_arbiter #(
  parameter int LINE_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_rd_req,
  input  logic [ADDR_WIDTH-1:0] ic_rd_addr,
  output logic                  ic_ret_valid,
  output logic [LINE_WIDTH-1:0] ic_ret_data,
  input  logic                  dc_rd_req,
  input  logic [ADDR_WIDTH-1:0] dc_rd_addr,
  output logic                  dc_ret_valid,
  output logic [LINE_WIDTH-1:0] dc_ret_data,
  input  logic                  dc_wr_req,
  input  logic [ADDR_WIDTH-1:0] dc_wr_addr,
  input  logic [LINE_WIDTH-1:0] dc_wr_data,
  output logic                  dc_wr_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_bvalid,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_IC, G_DC_RD, G_DC_WR} grant_t;

  // Clears the byte-offset bits so every memory access is a whole line.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  state_t                state_reg, state_next;
  grant_t                grant_reg, grant_next;
  logic                  last_rd_ic_reg;   // 1: last read grant went to the ICache
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LINE_WIDTH-1:0] wdata_reg;
  logic [LINE_WIDTH-1:0] ic_data_reg;
  logic [LINE_WIDTH-1:0] dc_data_reg;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  resp_match;
  logic                  resp_taken;

  // A write completes on mem_bvalid, a read on mem_rvalid; the other is ignored.
  assign resp_match = (grant_reg == G_DC_WR) ? mem_bvalid : mem_rvalid;
  assign resp_taken = resp_match &&
                      (((state_reg == ISSUE) && mem_ready) || (state_reg == WAIT));

  // Next-state, arbitration and grant-address selection.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    sel_addr   = '0;
    case (state_reg)
      IDLE: begin
        // Write-back first so a dirty victim reaches memory before its refill.
        if (dc_wr_req)                    grant_next = G_DC_WR;
        else if (ic_rd_req && dc_rd_req)  grant_next = last_rd_ic_reg ? G_DC_RD : G_IC;
        else if (ic_rd_req)               grant_next = G_IC;
        else if (dc_rd_req)               grant_next = G_DC_RD;
        else                              grant_next = G_NONE;
        if (grant_next != G_NONE) state_next = ISSUE;
      end
      ISSUE: begin
        if (mem_ready) state_next = resp_match ? RESP : WAIT;
      end
      WAIT: begin
        if (resp_match) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        grant_next = G_NONE;
      end
      default: begin
        state_next = IDLE;
        grant_next = G_NONE;
      end
    endcase
    case (grant_next)
      G_IC:    sel_addr = ic_rd_addr;
      G_DC_RD: sel_addr = dc_rd_addr;
      G_DC_WR: sel_addr = dc_wr_addr;
      default: sel_addr = '0;
    endcase
  end

  // State, grant, latched request fields and returned line data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_reg      <= G_NONE;
      last_rd_ic_reg <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      ic_data_reg    <= '0;
      dc_data_reg    <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      if ((state_reg == IDLE) && (grant_next != G_NONE)) begin
        addr_reg  <= sel_addr & LINE_MASK;
        we_reg    <= (grant_next == G_DC_WR);
        wdata_reg <= (grant_next == G_DC_WR) ? dc_wr_data : '0;
        if (grant_next == G_IC)    last_rd_ic_reg <= 1'b1;
        if (grant_next == G_DC_RD) last_rd_ic_reg <= 1'b0;
      end
      if (resp_taken && (grant_reg == G_IC))    ic_data_reg <= mem_rdata;
      if (resp_taken && (grant_reg == G_DC_RD)) dc_data_reg <= mem_rdata;
    end
  end

  assign mem_req      = (state_reg == ISSUE);
  assign mem_we       = we_reg;
  assign mem_addr     = addr_reg;
  assign mem_wdata    = wdata_reg;
  assign busy         = (state_reg != IDLE);
  assign ic_ret_valid = (state_reg == RESP) && (grant_reg == G_IC);
  assign dc_ret_valid = (state_reg == RESP) && (grant_reg == G_DC_RD);
  assign dc_wr_done   = (state_reg == RESP) && (grant_reg == G_DC_WR);
  assign ic_ret_data  = ic_data_reg;
  assign dc_ret_data  = dc_data_reg;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter: the bench itself plays the requesters
// and the memory, and checks each output against hand-computed values.
module tb_mem_line_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          ic_rd_req;
  logic [AW-1:0] ic_rd_addr;
  logic          ic_ret_valid;
  logic [LW-1:0] ic_ret_data;
  logic          dc_rd_req;
  logic [AW-1:0] dc_rd_addr;
  logic          dc_ret_valid;
  logic [LW-1:0] dc_ret_data;
  logic          dc_wr_req;
  logic [AW-1:0] dc_wr_addr;
  logic [LW-1:0] dc_wr_data;
  logic          dc_wr_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [LW-1:0] mem_rdata;
  logic          mem_bvalid;
  logic          busy;

  int errors = 0;
  int checks = 0;

  localparam logic [LW-1:0] A5_LINE = {32{8'hA5}};

  mem_line_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr),
    .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr),
    .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_done(dc_wr_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_bvalid(mem_bvalid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: wait (bounded) for mem_req, check the request, then
  // accept it with the matching response in the same cycle. Ends in RESP.
  task automatic serve(input string tag, input logic we, input logic [AW-1:0] addr,
                       input logic [LW-1:0] rd);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_req"}, LW'(mem_req), LW'(1));
    check_val({tag, "_addr"}, LW'(mem_addr), LW'(addr));
    check_val({tag, "_we"}, LW'(mem_we), LW'(we));
    mem_ready = 1'b1;
    if (we) mem_bvalid = 1'b1;
    else begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
    end
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_bvalid = 1'b0;
    $display("txn %s: we=%0d addr=%h", tag, we, addr);
  endtask

  initial begin
    rst = 1'b0;
    ic_rd_req = 0; ic_rd_addr = '0;
    dc_rd_req = 0; dc_rd_addr = '0;
    dc_wr_req = 0; dc_wr_addr = '0; dc_wr_data = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; mem_bvalid = 0;
    tick(); tick();

    // Reset state
    check_val("rst_mem_req", LW'(mem_req), LW'(0));
    check_val("rst_busy", LW'(busy), LW'(0));
    check_val("rst_mem_addr", LW'(mem_addr), LW'(0));
    check_val("rst_ic_data", ic_ret_data, '0);
    check_val("rst_valids", LW'({ic_ret_valid, dc_ret_valid, dc_wr_done}), LW'(0));

    // Single IC read, ready one cycle after mem_req rises, rvalid two later
    rst = 1'b1;
    ic_rd_req = 1; ic_rd_addr = 32'h1C00_0014;
    tick();
    check_val("t1_req", LW'(mem_req), LW'(1));
    check_val("t1_addr", LW'(mem_addr), LW'(32'h1C00_0000));
    check_val("t1_we", LW'(mem_we), LW'(0));
    tick();
    check_val("t1_req_hold", LW'(mem_req), LW'(1));
    mem_ready = 1;
    tick();
    mem_ready = 0;
    check_val("t1_req_drop", LW'(mem_req), LW'(0));
    check_val("t1_busy_wait", LW'(busy), LW'(1));
    tick();
    mem_rvalid = 1; mem_rdata = A5_LINE;
    tick();
    mem_rvalid = 0;
    check_val("t1_ic_valid", LW'(ic_ret_valid), LW'(1));
    check_val("t1_ic_data", ic_ret_data, A5_LINE);
    check_val("t1_dc_valid", LW'(dc_ret_valid), LW'(0));
    ic_rd_req = 0;
    $display("txn t1: ic read 1c000014 returned");
    tick();
    check_val("t1_ic_pulse_end", LW'(ic_ret_valid), LW'(0));
    check_val("t1_idle", LW'(busy), LW'(0));
    check_val("t1_ic_data_hold", ic_ret_data, A5_LINE);

    // Round robin from reset: IC, DC, IC with one IDLE cycle between
    rst = 1'b0;
    ic_rd_req = 1; ic_rd_addr = 32'h0000_0100;
    dc_rd_req = 1; dc_rd_addr = 32'h0000_0200;
    tick();
    rst = 1'b1;
    tick();
    serve("rr1_ic", 1'b0, 32'h0000_0100, LW'(1));
    check_val("rr1_ic_valid", LW'(ic_ret_valid), LW'(1));
    check_val("rr1_dc_valid", LW'(dc_ret_valid), LW'(0));
    tick();
    check_val("rr1_gap", LW'(busy), LW'(0));
    tick();
    check_val("rr2_busy", LW'(busy), LW'(1));
    serve("rr2_dc", 1'b0, 32'h0000_0200, LW'(2));
    check_val("rr2_dc_valid", LW'(dc_ret_valid), LW'(1));
    check_val("rr2_dc_data", dc_ret_data, LW'(2));
    tick();
    check_val("rr2_gap", LW'(busy), LW'(0));
    tick();
    serve("rr3_ic", 1'b0, 32'h0000_0100, LW'(3));
    check_val("rr3_ic_valid", LW'(ic_ret_valid), LW'(1));
    check_val("rr3_ic_data", ic_ret_data, LW'(3));
    ic_rd_req = 0; dc_rd_req = 0;
    tick();

    // Write-back beats a simultaneous refill
    dc_wr_req = 1; dc_wr_addr = 32'h0000_1040; dc_wr_data = LW'(32'hDEAD);
    dc_rd_req = 1; dc_rd_addr = 32'h0000_2000;
    tick();
    check_val("wb_wdata", mem_wdata, LW'(32'hDEAD));
    serve("wb_write", 1'b1, 32'h0000_1040, '0);
    check_val("wb_done", LW'(dc_wr_done), LW'(1));
    check_val("wb_no_rd_valid", LW'(dc_ret_valid), LW'(0));
    dc_wr_req = 0;
    tick();
    check_val("wb_done_end", LW'(dc_wr_done), LW'(0));
    tick();
    serve("wb_read", 1'b0, 32'h0000_2000, LW'(32'h1234));
    check_val("wb_rd_valid", LW'(dc_ret_valid), LW'(1));
    check_val("wb_rd_data", dc_ret_data, LW'(32'h1234));
    dc_rd_req = 0;
    tick();

    // Stall: mem_ready low for 10 cycles, request fields stay put
    ic_rd_req = 1; ic_rd_addr = 32'h3000_003F;
    tick();
    ic_rd_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      check_val("stall_req", LW'(mem_req), LW'(1));
      check_val("stall_addr", LW'(mem_addr), LW'(32'h3000_0020));
      check_val("stall_wdata", mem_wdata, '0);
      tick();
    end
    serve("stall_ic", 1'b0, 32'h3000_0020, LW'(32'h5555));
    check_val("stall_ic_valid", LW'(ic_ret_valid), LW'(1));
    check_val("stall_ic_data", ic_ret_data, LW'(32'h5555));
    ic_rd_req = 0;
    tick();

    // Minimum latency: ready and rvalid with the first mem_req cycle
    ic_rd_req = 1; ic_rd_addr = 32'h0000_0040;
    tick();
    check_val("lat_req", LW'(mem_req), LW'(1));
    check_val("lat_no_valid_e1", LW'(ic_ret_valid), LW'(0));
    mem_ready = 1; mem_rvalid = 1; mem_rdata = LW'(32'h7777);
    tick();
    mem_ready = 0; mem_rvalid = 0;
    check_val("lat_valid_e2", LW'(ic_ret_valid), LW'(1));
    check_val("lat_data", ic_ret_data, LW'(32'h7777));
    ic_rd_req = 0;
    $display("txn lat: ic read 00000040 returned");
    tick();
    check_val("lat_valid_e3", LW'(ic_ret_valid), LW'(0));
    // Stray rvalid in IDLE is ignored
    mem_rvalid = 1; mem_rdata = LW'(32'h9999);
    tick();
    mem_rvalid = 0;
    check_val("idle_rvalid_busy", LW'(busy), LW'(0));
    check_val("idle_rvalid_data", ic_ret_data, LW'(32'h7777));

    // Reset during WAIT
    ic_rd_req = 1; ic_rd_addr = 32'h0000_0500;
    tick();
    mem_ready = 1;
    tick();
    mem_ready = 0;
    check_val("rw_in_wait", LW'(busy), LW'(1));
    rst = 1'b0;
    tick();
    check_val("rw_busy", LW'(busy), LW'(0));
    check_val("rw_mem_addr", LW'(mem_addr), LW'(0));
    check_val("rw_ic_data", ic_ret_data, '0);
    check_val("rw_mem_req", LW'(mem_req), LW'(0));
    rst = 1'b1; ic_rd_req = 0;
    mem_rvalid = 1; mem_rdata = LW'(32'hBAD);
    tick();
    check_val("rw_late_valid", LW'(ic_ret_valid), LW'(0));
    tick();
    mem_rvalid = 0;
    check_val("rw_late_valid2", LW'(ic_ret_valid), LW'(0));
    check_val("rw_late_data", ic_ret_data, '0);
    ic_rd_req = 1; ic_rd_addr = 32'h0000_0610;
    tick();
    serve("rw_after", 1'b0, 32'h0000_0600, LW'(32'hC0DE));
    check_val("rw_after_valid", LW'(ic_ret_valid), LW'(1));
    check_val("rw_after_data", ic_ret_data, LW'(32'hC0DE));
    ic_rd_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
